// File: rtl/tpg_pattern_gen.sv
// Video timing and test-pattern generator: programmable syncs, DE,
// registered coordinates and four selectable patterns.
module tpg_pattern_gen #(
  parameter int PW       = 8,
  parameter int H_BITS   = 12,
  parameter int V_BITS   = 12,
  parameter int FRM_BITS = 8,
  parameter int CHK_LOG  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [3*PW-1:0]     solid_rgb,
  input  logic [3:0]          bar_shift,
  input  logic [H_BITS-1:0]   tHS_START,
  input  logic [H_BITS-1:0]   tHS_END,
  input  logic [H_BITS-1:0]   tHACT_START,
  input  logic [H_BITS-1:0]   tHACT_END,
  input  logic [H_BITS-1:0]   tH_END,
  input  logic [V_BITS-1:0]   tVS_START,
  input  logic [V_BITS-1:0]   tVS_END,
  input  logic [V_BITS-1:0]   tVACT_START,
  input  logic [V_BITS-1:0]   tVACT_END,
  input  logic [V_BITS-1:0]   tV_END,
  output logic                hs_q,
  output logic                vs_q,
  output logic                de_q,
  output logic                sof_q,
  output logic                eol_q,
  output logic [H_BITS-1:0]   x_q,
  output logic [V_BITS-1:0]   y_q,
  output logic [3*PW-1:0]     rgb,
  output logic [FRM_BITS-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_CHECK = 2'd3
  } patMode_t;

  logic [H_BITS-1:0] hCnt;
  logic [V_BITS-1:0] vCnt;
  logic [H_BITS-1:0] hNext;
  logic [V_BITS-1:0] vNext;
  logic              lineWrap;
  logic              frameWrap;
  logic              frameStart;

  patMode_t          modeLat;
  logic [3*PW-1:0]   colorLat;
  patMode_t          effMode;
  logic [3*PW-1:0]   effColor;

  logic              hsD;
  logic              vsD;
  logic              deD;
  logic              sofD;
  logic              eolD;
  logic [H_BITS-1:0] ax;
  logic [V_BITS-1:0] ay;
  logic [2:0]        barIdx;
  logic              chkOn;
  logic [PW-1:0]     rampVal;
  logic [3*PW-1:0]   rgbD;

  // Raster advance; >= lets a shrunk timing recover in one cycle
  always_comb begin
    lineWrap   = hCnt >= tH_END;
    frameWrap  = lineWrap && (vCnt >= tV_END);
    frameStart = en && (hCnt == '0) && (vCnt == '0);
    hNext      = lineWrap ? '0 : hCnt + H_BITS'(1);
    vNext      = vCnt;
    if (lineWrap) begin
      vNext = frameWrap ? '0 : vCnt + V_BITS'(1);
    end
  end

  // A new mode/colour takes effect on its own frame-start cycle
  always_comb begin
    effMode  = modeLat;
    effColor = colorLat;
    if (frameStart) begin
      effMode  = patMode_t'(mode);
      effColor = solid_rgb;
    end
  end

  // Decode sync, DE and pixel data from the current position
  always_comb begin
    hsD     = (hCnt >= tHS_START) && (hCnt < tHS_END);
    vsD     = (vCnt >= tVS_START) && (vCnt < tVS_END);
    deD     = (hCnt >= tHACT_START) && (hCnt < tHACT_END) &&
              (vCnt >= tVACT_START) && (vCnt < tVACT_END);
    ax      = hCnt - tHACT_START;
    ay      = vCnt - tVACT_START;
    sofD    = deD && (hCnt == tHACT_START) && (vCnt == tVACT_START);
    eolD    = deD && (hCnt == tHACT_END - H_BITS'(1));
    barIdx  = 3'(ax >> bar_shift);
    chkOn   = ax[CHK_LOG] ^ ay[CHK_LOG];
    rampVal = ax[PW-1:0] + PW'(frame_cnt);
    rgbD    = '0;
    if (deD) begin
      unique case (effMode)
        MODE_SOLID: rgbD = effColor;
        MODE_RAMP:  rgbD = {3{rampVal}};
        MODE_BARS:  rgbD = {{PW{barIdx[2]}},
                            {PW{barIdx[1]}},
                            {PW{barIdx[0]}}};
        MODE_CHECK: rgbD = {3*PW{chkOn}};
      endcase
    end
  end

  // Position, frame count and pattern latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCnt      <= '0;
      vCnt      <= '0;
      frame_cnt <= '0;
      modeLat   <= MODE_SOLID;
      colorLat  <= '0;
    end else if (en) begin
      hCnt <= hNext;
      vCnt <= vNext;
      if (frameWrap) begin
        frame_cnt <= frame_cnt + FRM_BITS'(1);
      end
      if (frameStart) begin
        modeLat  <= patMode_t'(mode);
        colorLat <= solid_rgb;
      end
    end
  end

  // Output register; a stalled raster blanks data but holds syncs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      rgb   <= '0;
    end else if (en) begin
      hs_q  <= hsD;
      vs_q  <= vsD;
      de_q  <= deD;
      sof_q <= sofD;
      eol_q <= eolD;
      x_q   <= deD ? ax : '0;
      y_q   <= deD ? ay : '0;
      rgb   <= rgbD;
    end else begin
      de_q  <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      rgb   <= '0;
    end
  end

endmodule

// File: tb/tb_tpg_pattern_gen.sv
// Bench for tpg_pattern_gen: directed timing/pattern sequences,
// a pattern vector table and a randomized reference-model run.
module tb_tpg_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] solidRgb;
  logic [3:0]  barShift;
  logic [11:0] hsS, hsE, haS, haE, hEnd;
  logic [11:0] vsS, vsE, vaS, vaE, vEnd;
  logic        hsQ, vsQ, deQ, sofQ, eolQ;
  logic [11:0] xQ, yQ;
  logic [23:0] rgbQ;
  logic [7:0]  frameCnt;

  int nTests = 0;
  int nFail  = 0;

  tpg_pattern_gen #(.CHK_LOG(1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .solid_rgb(solidRgb), .bar_shift(barShift),
    .tHS_START(hsS), .tHS_END(hsE),
    .tHACT_START(haS), .tHACT_END(haE), .tH_END(hEnd),
    .tVS_START(vsS), .tVS_END(vsE),
    .tVACT_START(vaS), .tVACT_END(vaE), .tV_END(vEnd),
    .hs_q(hsQ), .vs_q(vsQ), .de_q(deQ), .sof_q(sofQ),
    .eol_q(eolQ), .x_q(xQ), .y_q(yQ), .rgb(rgbQ),
    .frame_cnt(frameCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  sh;
    int          ay;
    int          ax;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] outs();
    return {3'b0, hsQ, vsQ, deQ, sofQ, eolQ, xQ, yQ, rgbQ, frameCnt};
  endfunction

  task automatic setCommon();
    hEnd = 9; hsS = 0; hsE = 2; haS = 3; haE = 9;
    vEnd = 4; vsS = 0; vsE = 1; vaS = 1; vaE = 4;
    mode = 0; solidRgb = 24'h123456; barShift = 0; en = 1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // checks one 50-cycle frame of mode-1 output against base+index
  task automatic rampFrame(int base);
    int bad = 0;
    int n = 0;
    int idx = 0;
    logic [7:0] v;
    repeat (50) begin
      step(1);
      if (deQ) begin
        v = 8'((base + idx) % 256);
        if (rgbQ !== {v, v, v}) bad++;
        idx++;
        n++;
      end else begin
        idx = 0;
      end
    end
    check($sformatf("ramp base %0d", base), 64'(bad), 0);
    check("ramp de count", 64'(n), 18);
  endtask

  // reference model of the pattern colour for one active pixel
  function automatic logic [23:0] patModel(int m, logic [23:0] col,
                                           int ax, int ay, int f,
                                           int bs);
    int v, idx;
    case (m)
      0: return col;
      1: begin
        v = (ax + f) % 256;
        return 24'(v * 65536 + v * 256 + v);
      end
      2: begin
        idx = (ax >> bs) % 8;
        return 24'((((idx / 4) % 2) != 0 ? 24'hFF0000 : 0) |
                   (((idx / 2) % 2) != 0 ? 24'h00FF00 : 0) |
                   ((idx % 2) != 0 ? 24'h0000FF : 0));
      end
      default:
        return (((ax / 2) + (ay / 2)) % 2) != 0 ? 24'hFFFFFF : 0;
    endcase
  endfunction

  task automatic randomPhase(int cycles);
    int mx = 0, my = 0, mf = 0, mMode = 0;
    logic [23:0] mCol = 0;
    logic eHs = 0, eVs = 0, eDe, eSof, eEol;
    int ax, ay;
    logic [11:0] eX, eY;
    logic [23:0] eRgb;
    logic [63:0] exp;
    hEnd = 12'($urandom_range(3, 15));
    hsS = 12'($urandom_range(0, 16));
    hsE = 12'($urandom_range(0, 16));
    haS = 12'($urandom_range(0, 8));
    haE = 12'($urandom_range(0, 17));
    vEnd = 12'($urandom_range(2, 6));
    vsS = 12'($urandom_range(0, 7));
    vsE = 12'($urandom_range(0, 7));
    vaS = 12'($urandom_range(0, 3));
    vaE = 12'($urandom_range(0, 7));
    doReset();
    repeat (cycles) begin
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 19) == 0) solidRgb = 24'($urandom);
      barShift = 4'($urandom_range(0, 4));
      if (en) begin
        if (mx == 0 && my == 0) begin
          mMode = int'(mode);
          mCol = solidRgb;
        end
        eHs = mx >= int'(hsS) && mx < int'(hsE);
        eVs = my >= int'(vsS) && my < int'(vsE);
        eDe = mx >= int'(haS) && mx < int'(haE) &&
              my >= int'(vaS) && my < int'(vaE);
        ax = (mx - int'(haS)) & 4095;
        ay = (my - int'(vaS)) & 4095;
        eSof = eDe && mx == int'(haS) && my == int'(vaS);
        eEol = eDe && mx == int'(haE) - 1;
        eX = eDe ? 12'(ax) : 12'd0;
        eY = eDe ? 12'(ay) : 12'd0;
        eRgb = eDe ? patModel(mMode, mCol, ax, ay, mf,
                              int'(barShift)) : 24'd0;
        if (mx >= int'(hEnd)) begin
          mx = 0;
          if (my >= int'(vEnd)) begin
            my = 0;
            mf = (mf + 1) % 256;
          end else begin
            my++;
          end
        end else begin
          mx++;
        end
      end else begin
        eDe = 0; eSof = 0; eEol = 0; eX = 0; eY = 0; eRgb = 0;
      end
      exp = {3'b0, eHs, eVs, eDe, eSof, eEol, eX, eY, eRgb, 8'(mf)};
      step(1);
      check("random", outs(), exp);
    end
  endtask

  initial begin
    int hsN, vsN, deN, eolN, sofN, bad, n, guard, cnt;
    logic [11:0] savedX, savedY;

    tbl[0]  = '{2'd2, 4'd1, 0, 0,  24'h000000};
    tbl[1]  = '{2'd2, 4'd1, 0, 1,  24'h000000};
    tbl[2]  = '{2'd2, 4'd1, 0, 2,  24'h0000FF};
    tbl[3]  = '{2'd2, 4'd1, 0, 3,  24'h0000FF};
    tbl[4]  = '{2'd2, 4'd1, 1, 4,  24'h00FF00};
    tbl[5]  = '{2'd2, 4'd1, 1, 6,  24'h00FFFF};
    tbl[6]  = '{2'd2, 4'd1, 2, 8,  24'hFF0000};
    tbl[7]  = '{2'd2, 4'd1, 2, 10, 24'hFF00FF};
    tbl[8]  = '{2'd2, 4'd1, 3, 12, 24'hFFFF00};
    tbl[9]  = '{2'd2, 4'd1, 3, 15, 24'hFFFFFF};
    tbl[10] = '{2'd2, 4'd2, 0, 4,  24'h0000FF};
    tbl[11] = '{2'd2, 4'd2, 0, 15, 24'h00FFFF};
    tbl[12] = '{2'd3, 4'd0, 0, 0,  24'h000000};
    tbl[13] = '{2'd3, 4'd0, 0, 2,  24'hFFFFFF};
    tbl[14] = '{2'd3, 4'd0, 0, 4,  24'h000000};
    tbl[15] = '{2'd3, 4'd0, 2, 0,  24'hFFFFFF};
    tbl[16] = '{2'd3, 4'd0, 2, 2,  24'h000000};
    tbl[17] = '{2'd3, 4'd0, 1, 3,  24'hFFFFFF};

    // reset state and one full frame of common timing
    setCommon();
    rst = 1'b1;
    #12;
    check("reset outputs", outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    hsN = 0; vsN = 0; deN = 0; eolN = 0; sofN = 0; bad = 0;
    repeat (50) begin
      step(1);
      hsN += int'(hsQ);
      vsN += int'(vsQ);
      deN += int'(deQ);
      eolN += int'(eolQ);
      if (sofQ) begin
        sofN++;
        if (xQ != 0 || yQ != 0) bad++;
      end
      if (deQ && rgbQ !== 24'h123456) bad++;
      if (!deQ && rgbQ !== 0) bad++;
    end
    check("hs count", 64'(hsN), 10);
    check("vs count", 64'(vsN), 10);
    check("de count", 64'(deN), 18);
    check("eol count", 64'(eolN), 3);
    check("sof count", 64'(sofN), 1);
    check("solid/sof coords", 64'(bad), 0);
    check("frame_cnt after 1", 64'(frameCnt), 1);

    // mid-frame mode switch is ignored until next frame start
    step(20);
    mode = 2'd1;
    bad = 0; n = 0;
    repeat (30) begin
      step(1);
      if (deQ) begin
        n++;
        if (rgbQ !== 24'h123456) bad++;
      end
    end
    check("latched solid", 64'(bad), 0);
    check("latched de", 64'(n), 12);
    rampFrame(2);
    rampFrame(3);

    guard = 0;
    while (frameCnt != 8'd255 && guard < 20000) begin
      step(1);
      guard++;
    end
    check("frame reach 255", 64'(frameCnt), 255);
    rampFrame(255);
    check("frame wrap", 64'(frameCnt), 0);

    // en dropped mid-line for 5 cycles
    mode = 2'd0;
    guard = 0;
    while (!(deQ && xQ == 12'd2) && guard < 200) begin
      step(1);
      guard++;
    end
    savedX = xQ;
    savedY = yQ;
    en = 1'b0;
    bad = 0;
    repeat (5) begin
      step(1);
      if (deQ || sofQ || eolQ || rgbQ != 0) bad++;
    end
    check("en low blank", 64'(bad), 0);
    en = 1'b1;
    step(1);
    check("en resume", {deQ, xQ, yQ}, {1'b1, savedX + 12'd1, savedY});

    // asynchronous reset mid-frame
    step(7);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async reset", outs(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (!sofQ && cnt < 100) begin
      step(1);
      cnt++;
    end
    check("sof after reset", 64'(cnt), 14);

    // shrink line length below the current x
    guard = 0;
    while (!(deQ && xQ == 12'd3) && guard < 100) begin
      step(1);
      guard++;
    end
    hEnd = 12'd5;
    step(1);
    check("pre-shrink pixel", {deQ, xQ}, {1'b1, 12'd4});
    step(1);
    check("shrink wrap", {hsQ, deQ}, 2'b10);
    hEnd = 12'd9;

    // pattern vector table on wide timing
    hEnd = 19; hsS = 0; hsE = 0; haS = 2; haE = 18;
    vEnd = 4; vsS = 0; vsE = 0; vaS = 0; vaE = 4;
    doReset();
    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      barShift = tbl[i].sh;
      step(100);
      guard = 0;
      while (!(deQ && int'(yQ) == tbl[i].ay &&
               int'(xQ) == tbl[i].ax) && guard < 200) begin
        step(1);
        guard++;
      end
      check($sformatf("table %0d", i), {deQ, rgbQ}, {1'b1, tbl[i].exp});
    end

    // randomized run against the reference model
    mode = 0;
    for (int p = 0; p < 4; p++) randomPhase(400);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
